// File: rtl/uart_ctrl_tl_buffer_pkg.sv
// TileLink-UL field widths, beat structs and opcodes shared by the UART TL buffer.
// Ports: none (package only).
package uart_tl_pkg;

    localparam int TL_OP_W      = 3;
    localparam int TL_A_PARAM_W = 3;
    localparam int TL_D_PARAM_W = 2;
    localparam int TL_SIZE_W    = 2;
    localparam int TL_SRC_W     = 9;
    localparam int TL_SINK_W    = 1;
    localparam int TL_ADDR_W    = 31;
    localparam int TL_MASK_W    = 8;
    localparam int TL_DATA_W    = 64;

    localparam logic [TL_OP_W-1:0] PutFullData    = 3'd0;
    localparam logic [TL_OP_W-1:0] PutPartialData = 3'd1;
    localparam logic [TL_OP_W-1:0] Get            = 3'd4;
    localparam logic [TL_OP_W-1:0] AccessAck      = 3'd0;
    localparam logic [TL_OP_W-1:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic [TL_OP_W-1:0]      opcode;
        logic [TL_A_PARAM_W-1:0] param;
        logic [TL_SIZE_W-1:0]    size;
        logic [TL_SRC_W-1:0]     source;
        logic [TL_ADDR_W-1:0]    address;
        logic [TL_MASK_W-1:0]    mask;
        logic [TL_DATA_W-1:0]    data;
        logic                    corrupt;
    } tl_a_beat_t;

    typedef struct packed {
        logic [TL_OP_W-1:0]      opcode;
        logic [TL_D_PARAM_W-1:0] param;
        logic [TL_SIZE_W-1:0]    size;
        logic [TL_SRC_W-1:0]     source;
        logic [TL_SINK_W-1:0]    sink;
        logic                    denied;
        logic [TL_DATA_W-1:0]    data;
        logic                    corrupt;
    } tl_d_beat_t;

endpackage

// File: rtl/uart_ctrl_tl_buffer_queue.sv
// Circular-buffer valid/ready queue, registered output, no bypass.
// Ports: i_valid/o_ready/i_data in, o_valid/i_ready/o_data out, o_empty, o_full.
module tl_buf_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_ready = !o_full;
    assign o_valid = !o_empty;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/uart_ctrl_tl_buffer.sv
// TL-UL A/D buffer in front of the UART control port with outstanding-request cap.
// Ports: in_a_* (from xbar), out_a_* (to UART), out_d_* (from UART), in_d_* (to xbar), busy.
module uart_ctrl_tl_buffer
    import uart_tl_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_a_valid,
    output logic         in_a_ready,
    input  logic [2:0]   in_a_bits_opcode,
    input  logic [2:0]   in_a_bits_param,
    input  logic [1:0]   in_a_bits_size,
    input  logic [8:0]   in_a_bits_source,
    input  logic [30:0]  in_a_bits_address,
    input  logic [7:0]   in_a_bits_mask,
    input  logic [63:0]  in_a_bits_data,
    input  logic         in_a_bits_corrupt,
    output logic         out_a_valid,
    input  logic         out_a_ready,
    output logic [2:0]   out_a_bits_opcode,
    output logic [2:0]   out_a_bits_param,
    output logic [1:0]   out_a_bits_size,
    output logic [8:0]   out_a_bits_source,
    output logic [30:0]  out_a_bits_address,
    output logic [7:0]   out_a_bits_mask,
    output logic [63:0]  out_a_bits_data,
    output logic         out_a_bits_corrupt,
    input  logic         out_d_valid,
    output logic         out_d_ready,
    input  logic [2:0]   out_d_bits_opcode,
    input  logic [1:0]   out_d_bits_param,
    input  logic [1:0]   out_d_bits_size,
    input  logic [8:0]   out_d_bits_source,
    input  logic         out_d_bits_sink,
    input  logic         out_d_bits_denied,
    input  logic [63:0]  out_d_bits_data,
    input  logic         out_d_bits_corrupt,
    output logic         in_d_valid,
    input  logic         in_d_ready,
    output logic [2:0]   in_d_bits_opcode,
    output logic [1:0]   in_d_bits_param,
    output logic [1:0]   in_d_bits_size,
    output logic [8:0]   in_d_bits_source,
    output logic         in_d_bits_sink,
    output logic         in_d_bits_denied,
    output logic [63:0]  in_d_bits_data,
    output logic         in_d_bits_corrupt,
    output logic         busy
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);

    tl_a_beat_t    w_a_in;
    tl_a_beat_t    w_a_out;
    tl_d_beat_t    w_d_in;
    tl_d_beat_t    w_d_out;
    logic          w_aq_valid;
    logic          w_aq_ready;
    logic          w_a_empty;
    logic          w_a_full;
    logic          w_d_empty;
    logic          w_d_full;
    logic          w_a_gate;
    logic          w_a_fire;
    logic          w_d_fire;
    logic [IW-1:0] r_inflight;

    assign w_a_in = '{
        opcode: in_a_bits_opcode, param: in_a_bits_param,
        size: in_a_bits_size, source: in_a_bits_source,
        address: in_a_bits_address, mask: in_a_bits_mask,
        data: in_a_bits_data, corrupt: in_a_bits_corrupt};

    assign w_d_in = '{
        opcode: out_d_bits_opcode, param: out_d_bits_param,
        size: out_d_bits_size, source: out_d_bits_source,
        sink: out_d_bits_sink, denied: out_d_bits_denied,
        data: out_d_bits_data, corrupt: out_d_bits_corrupt};

    // Gate depends only on the counter, so a raised out_a_valid
    // cannot fall until its own fire.
    assign w_a_gate    = (r_inflight < MAX_CNT);
    assign out_a_valid = w_aq_valid && w_a_gate;
    assign w_aq_ready  = out_a_ready && w_a_gate;
    assign w_a_fire    = out_a_valid && out_a_ready;
    assign w_d_fire    = in_d_valid && in_d_ready;
    assign busy        = !w_a_empty || !w_d_empty || (r_inflight != '0);

    tl_buf_queue #(.WIDTH($bits(tl_a_beat_t)), .DEPTH(DEPTH)) u_a_q (
        .clock   (clock),
        .reset   (reset),
        .i_valid (in_a_valid),
        .o_ready (in_a_ready),
        .i_data  (w_a_in),
        .o_valid (w_aq_valid),
        .i_ready (w_aq_ready),
        .o_data  (w_a_out),
        .o_empty (w_a_empty),
        .o_full  (w_a_full)
    );

    tl_buf_queue #(.WIDTH($bits(tl_d_beat_t)), .DEPTH(DEPTH)) u_d_q (
        .clock   (clock),
        .reset   (reset),
        .i_valid (out_d_valid),
        .o_ready (out_d_ready),
        .i_data  (w_d_in),
        .o_valid (in_d_valid),
        .i_ready (in_d_ready),
        .o_data  (w_d_out),
        .o_empty (w_d_empty),
        .o_full  (w_d_full)
    );

    assign out_a_bits_opcode  = w_a_out.opcode;
    assign out_a_bits_param   = w_a_out.param;
    assign out_a_bits_size    = w_a_out.size;
    assign out_a_bits_source  = w_a_out.source;
    assign out_a_bits_address = w_a_out.address;
    assign out_a_bits_mask    = w_a_out.mask;
    assign out_a_bits_data    = w_a_out.data;
    assign out_a_bits_corrupt = w_a_out.corrupt;

    assign in_d_bits_opcode   = w_d_out.opcode;
    assign in_d_bits_param    = w_d_out.param;
    assign in_d_bits_size     = w_d_out.size;
    assign in_d_bits_source   = w_d_out.source;
    assign in_d_bits_sink     = w_d_out.sink;
    assign in_d_bits_denied   = w_d_out.denied;
    assign in_d_bits_data     = w_d_out.data;
    assign in_d_bits_corrupt  = w_d_out.corrupt;

    // Counter saturates at 0 on a stray D; the assertion flags it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_a_fire, w_d_fire})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= (r_inflight == '0) ?
                                        '0 : r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
        !(w_d_fire && (r_inflight == '0)));

    a_ready_full: assert property (@(posedge clock) disable iff (!reset)
        (in_a_ready == !w_a_full) && (out_d_ready == !w_d_full));

endmodule

// File: doc/uart_ctrl_tl_buffer.md
# uart_ctrl_tl_buffer

Registered TileLink-UL buffer stage that sits directly upstream of the UART's control port, between the peripheral bus crossbar and the UART's `control_xing_in` A/D channels. It decouples bus timing from the UART with a 2-entry queue on each of the A and D channels. It also caps the number of outstanding requests issued to the UART, and reports buffer activity.

## Interface
Parameters:
- `DEPTH`, 2 — entries per channel queue; power of two, at least 2.
- `MAX_INFLIGHT`, 4 — maximum A beats issued downstream and not yet answered on D; at least 1.

Ports:
- `clock`  input  1  — single clock for the block.
- `reset`  input  1  — asynchronous, active-low.
- `in_a_valid` / `in_a_ready`  input / output  1 / 1  — A handshake from the crossbar.
- `in_a_bits_{opcode,param,size,source,address,mask,data,corrupt}`  input  3/3/2/9/31/8/64/1  — A payload from the crossbar.
- `out_a_valid` / `out_a_ready`  output / input  1 / 1  — A handshake toward the UART.
- `out_a_bits_*`  output  same widths as `in_a_bits_*`  — A payload toward the UART.
- `out_d_valid` / `out_d_ready`  input / output  1 / 1  — D handshake from the UART.
- `out_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}`  input  3/2/2/9/1/1/64/1  — D payload from the UART.
- `in_d_valid` / `in_d_ready`  output / input  1 / 1  — D handshake toward the crossbar.
- `in_d_bits_*`  output  same widths as `out_d_bits_*`  — D payload toward the crossbar.
- `busy`  output  1  — any queue entry is occupied or `inflight` is non-zero.

## Operation
- **A queue.** Enqueues on `in_a_valid && in_a_ready`.
  - `in_a_ready = !a_full`. It never depends on `out_a_ready`.
- **A issue gating.** `out_a_valid = !a_empty && (inflight < MAX_INFLIGHT)`.
  - The queue dequeues on `out_a_valid && out_a_ready`.
- **D queue.** Enqueues on `out_d_valid && out_d_ready`, with `out_d_ready = !d_full`.
  - `in_d_valid = !d_empty`.
  - The queue dequeues on `in_d_valid && in_d_ready`.
- **inflight counter.** Width `$clog2(MAX_INFLIGHT+1)`.
  - +1 on an `out_a` fire.
  - −1 on an `in_d` fire.
  - Unchanged when both fire in the same cycle.
  - Never wraps. Underflow (a D fire when `inflight==0`) is a protocol error: flag it with an assertion; the RTL saturates at 0.
- **Payload.** Fields pass through bit-exact and in order. No field is interpreted, so each A produces exactly one D (TL-UL, single beat).
- **Queue storage.** Each queue is a circular buffer with a read pointer, a write pointer and an occupancy count.
  - Pointers wrap modulo `DEPTH`.
  - Full: `count==DEPTH`. Empty: `count==0`.
  - Simultaneous enqueue and dequeue when full: the enqueue is refused because ready is low; the dequeue proceeds.
  - Simultaneous enqueue and dequeue when non-empty and not full: count is unchanged and both pointers advance.
  - No bypass: a beat enqueued in cycle N is first visible at the output in cycle N+1.
- **Reset (asynchronous assert, deassert synchronised upstream).**
  - Pointers, counts and `inflight` go to 0. Payload registers are not reset.
  - Reset values: `out_a_valid=0`, `in_d_valid=0`, `in_a_ready=1`, `out_d_ready=1`, `busy=0`.
  - Reset mid-transaction drops all queued beats and outstanding state. Nothing is replayed.

## Timing
- A-channel latency: 1 cycle from the `in_a` fire to `out_a_valid` when the queue was empty and `inflight < MAX_INFLIGHT`.
- D-channel latency: 1 cycle from the `out_d` fire to `in_d_valid`.
- Throughput is 1 beat/cycle per channel with `DEPTH>=2` and the sink always ready.
- `out_a_valid`, once asserted, stays asserted with stable payload until accepted. The only exception is reset: `inflight` cannot increase without an `out_a` fire, so the gate cannot drop `out_a_valid` after it has risen.
- All outputs are driven from registers or from simple gates on local register state. No combinational path runs from `out_a_ready` to `in_a_ready`, or from `in_d_ready` to `out_d_ready`.

## Structure
- **Shared package `uart_tl_pkg`:**
  - TL-UL field widths: `TL_SRC_W=9`, `TL_ADDR_W=31`, `TL_DATA_W=64`, `TL_MASK_W=8`, `TL_SIZE_W=2`.
  - Packed structs `tl_a_beat_t` and `tl_d_beat_t`.
  - Opcode constants: `PutFullData=0`, `PutPartialData=1`, `Get=4`, `AccessAck=0`, `AccessAckData=1`.
- **One sub-module, `tl_buf_queue`:**
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: valid/ready/data on each side, plus `empty` and `full`.
  - Instantiated twice, for A and D. The top level adds only the `inflight` counter and the gating logic.

## Test plan
- **Single Get.** Send a Get with `source=0x1A5`, `address=0x10013000`. Required: `out_a` valid 1 cycle later with identical fields. Return AccessAckData with `data=0x55`. Required: `in_d` shows `data=0x55`, `source=0x1A5` 1 cycle later; `inflight` returns to 0; `busy` falls.
- **A back-pressure.** Hold `out_a_ready=0` and present 3 Puts back-to-back. Required: `in_a_ready` drops after the 2nd is accepted. Release `out_a_ready`. Required: all 3 Puts are delivered in order.
- **In-flight cap.** With the UART never responding, send 6 Gets. Required: exactly 4 `out_a` fires. Return 1 D. Required: the 5th A issues the next cycle.
- **Simultaneous fires.** With `inflight=2`, make `out_a` and `in_d` fire in the same cycle. Required: `inflight` stays at 2.
- **Reset mid-operation.** With 2 A entries queued and `inflight=3`, assert reset. Required: the reset values listed under Operation appear immediately; after release, no stale beat is emitted.
- **Pointer wrap.** Stream 10 beats through each queue with random ready stalls. Required: every beat delivered in order and bit-exact.
